window_line_buffer: RTL



---
 rtl/window_line_buffer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/window_line_buffer.sv
// Raster pixel stream -> OPE_WIDTH x OPE_WIDTH window (line-buffered) for the median/sobel stage.
// Optional WINDOW_BORDER_ZERO_EN zeroes pixels of window columns that fall outside the image line.
module window_line_buffer #(
  parameter int                   TAG_WIDTH    = 2,
  parameter logic [TAG_WIDTH-1:0] INVALID_TAG  = 2'd0,
  parameter logic [TAG_WIDTH-1:0] DATA_TAG0    = 2'd1,
  parameter logic [TAG_WIDTH-1:0] DATA_TAG1    = 2'd2,
  parameter logic [TAG_WIDTH-1:0] DATA_END_TAG = 2'd3,
  parameter int                   OPE_WIDTH    = 9,
  parameter int                   IMG_WIDTH    = 640,
  parameter int                   DATA_WIDTH   = 8 + TAG_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      refresh,
  input  logic [DATA_WIDTH-1:0]                     in,
  output logic [DATA_WIDTH*OPE_WIDTH*OPE_WIDTH-1:0] data_bus,
  output logic                                      busy
);

  localparam int PIX_W     = DATA_WIDTH - TAG_WIDTH;
  localparam int HALF      = OPE_WIDTH / 2;
  localparam int LB_DEPTH  = IMG_WIDTH - OPE_WIDTH;
  localparam int FLUSH_LEN = HALF * (IMG_WIDTH + 1);
  localparam int FW        = $clog2(FLUSH_LEN + 1);
  localparam int CTAG_LSB  = (HALF * OPE_WIDTH + HALF) * DATA_WIDTH + PIX_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_END   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                                           state;
  logic [FW-1:0]                                        flush_cnt;
  logic                                                 adv;
  logic                                                 shift;
  logic [DATA_WIDTH-1:0]                                shift_px;
  logic [TAG_WIDTH-1:0]                                 in_tag;
  logic                                                 in_valid;
  logic                                                 in_end;
  logic [OPE_WIDTH-1:0][OPE_WIDTH-1:0][DATA_WIDTH-1:0]  w;
  logic [DATA_WIDTH-1:0]                                lb [OPE_WIDTH-1][LB_DEPTH];
  logic [OPE_WIDTH-1:0]                                 col_zero;

  assign in_tag   = in[DATA_WIDTH-1 -: TAG_WIDTH];
  assign in_valid = (in_tag == DATA_TAG0) || (in_tag == DATA_TAG1);
  assign in_end   = (in_tag == DATA_END_TAG);
  assign busy     = (state == S_FLUSH);

  // FLUSH pushes zero padding so the last real rows drain to the centre
  always_comb begin
    shift    = 1'b0;
    shift_px = in;
    case (state)
      S_IDLE, S_RUN: shift = in_valid;
      S_FLUSH: begin
        shift    = 1'b1;
        shift_px = {INVALID_TAG, {PIX_W{1'b0}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || refresh) begin
      state     <= S_IDLE;
      flush_cnt <= '0;
      adv       <= 1'b0;
    end else begin
      adv <= shift;
      case (state)
        S_IDLE, S_RUN: begin
          if (in_valid) begin
            state <= S_RUN;
          end else if (in_end) begin
            state     <= S_FLUSH;
            flush_cnt <= FW'(FLUSH_LEN);
          end
        end
        S_FLUSH: begin
          flush_cnt <= flush_cnt - 1'b1;
          if (flush_cnt <= FW'(1)) state <= S_END;
        end
        S_END:   state <= S_DONE;
        S_DONE:  ;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || refresh) begin
      w <= '0;
      for (int y = 0; y < OPE_WIDTH - 1; y++)
        for (int d = 0; d < LB_DEPTH; d++)
          lb[y][d] <= '0;
    end else if (shift) begin
      for (int y = 0; y < OPE_WIDTH; y++)
        for (int x = 0; x < OPE_WIDTH - 1; x++)
          w[y][x] <= w[y][x+1];
      for (int y = 0; y < OPE_WIDTH - 1; y++) begin
        w[y][OPE_WIDTH-1] <= lb[y][LB_DEPTH-1];
        lb[y][0]          <= w[y+1][0];
        for (int d = 1; d < LB_DEPTH; d++)
          lb[y][d] <= lb[y][d-1];
      end
      w[OPE_WIDTH-1][OPE_WIDTH-1] <= shift_px;
    end
  end

`ifdef WINDOW_BORDER_ZERO_EN
  localparam int          CW     = $clog2(IMG_WIDTH);
  localparam logic [CW:0] IMG_X  = (CW+1)'(IMG_WIDTH);
  localparam logic [CW:0] HALF_X = (CW+1)'(HALF);
  localparam logic [CW:0] H1_X   = (CW+1)'(HALF + 1);

  // ncol counts shifts mod IMG_WIDTH, so the newest pixel sits in column ncol-1
  logic [CW-1:0] ncol;
  logic [CW:0]   ccol;

  always_ff @(posedge clk) begin
    if (rst || refresh)
      ncol <= '0;
    else if (shift)
      ncol <= (ncol == CW'(IMG_WIDTH - 1)) ? '0 : ncol + 1'b1;
  end

  assign ccol = ({1'b0, ncol} >= H1_X) ? {1'b0, ncol} - H1_X
                                       : {1'b0, ncol} + IMG_X - H1_X;

  // pos is image column + HALF, keeping the arithmetic unsigned
  for (genvar x = 0; x < OPE_WIDTH; x++) begin : g_col
    logic [CW:0] pos;
    assign pos         = ccol + (CW+1)'(x);
    assign col_zero[x] = (pos < HALF_X) || (pos >= IMG_X + HALF_X);
  end
`else
  assign col_zero = '0;
`endif

  // centre tag marks a pixel valid only in the cycle right after it shifted in
  always_comb begin
    data_bus = '0;
    for (int y = 0; y < OPE_WIDTH; y++)
      for (int x = 0; x < OPE_WIDTH; x++) begin
        data_bus[(y*OPE_WIDTH+x)*DATA_WIDTH +: DATA_WIDTH] = w[y][x];
        if (col_zero[x]) data_bus[(y*OPE_WIDTH+x)*DATA_WIDTH +: PIX_W] = '0;
      end
    if (state == S_END)
      data_bus[CTAG_LSB +: TAG_WIDTH] = DATA_END_TAG;
    else if (!adv)
      data_bus[CTAG_LSB +: TAG_WIDTH] = INVALID_TAG;
  end

endmodule
